// File: rtl/gzip_stored_block_decoder.sv
// gzip_stored_block_decoder
// Parses DEFLATE stored (BTYPE=00) blocks out of a 32-bit word stream and
// writes each block's payload bytes into a byte-wide FIFO.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   empty_in          source word FIFO empty
//   rd_en_in          source FIFO read strobe (din_32 valid one cycle later)
//   din_32            stream word, first stream byte on [7:0], LSB-first bits
//   full_out          destination byte FIFO full
//   wr_en_out         destination write strobe (registered)
//   dout_byte         payload byte (registered)
//   block_done        1-cycle pulse after the last byte of a block
//   stream_done       1-cycle pulse after the BFINAL block completes
//   last_block        BFINAL of the current block
//   error             sticky error flag
//   error_code        1: BTYPE!=00, 2: NLEN!=~LEN, 3: LEN>MAX_LEN
module gzip_stored_block_decoder #(
    parameter int unsigned MAX_LEN = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        empty_in,
    output logic        rd_en_in,
    input  logic [31:0] din_32,
    input  logic        full_out,
    output logic        wr_en_out,
    output logic [7:0]  dout_byte,
    output logic        block_done,
    output logic        stream_done,
    output logic        last_block,
    output logic        error,
    output logic [1:0]  error_code
);

    typedef enum logic [2:0] {
        S_HDR, S_ALIGN, S_LEN, S_NLEN, S_COPY, S_BEND, S_ERR
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] buf_q, buf_d;
    logic [6:0]  cnt_q, cnt_d;
    logic        pend_q;
    logic [15:0] len_q, len_d;
    logic [15:0] rem_q, rem_d;
    logic        wr_en_q, wr_en_d;
    logic [7:0]  dout_q, dout_d;
    logic        bdone_q, bdone_d;
    logic        sdone_q, sdone_d;
    logic        last_q, last_d;
    logic        err_q, err_d;
    logic [1:0]  code_q, code_d;

    logic [6:0]  consume;
    logic [6:0]  cnt_post;
    logic [15:0] nlen;

    // At most one word in flight, so the append never overflows 64 bits.
    assign rd_en_in = !rst && (cnt_q <= 7'd32) && !empty_in && !pend_q
                      && (state_q != S_ERR);

    assign nlen = buf_q[15:0];

    always_comb begin
        state_d = state_q;
        consume = 7'd0;
        len_d   = len_q;
        rem_d   = rem_q;
        wr_en_d = 1'b0;
        dout_d  = dout_q;
        bdone_d = 1'b0;
        sdone_d = 1'b0;
        last_d  = last_q;
        err_d   = err_q;
        code_d  = code_q;

        case (state_q)
            S_HDR: begin
                if (cnt_q >= 7'd3) begin
                    last_d  = buf_q[0];
                    consume = 7'd3;
                    if (buf_q[2:1] != 2'b00) begin
                        err_d   = 1'b1;
                        code_d  = 2'd1;
                        state_d = S_ERR;
                    end else begin
                        state_d = S_ALIGN;
                    end
                end
            end
            S_ALIGN: begin
                // Whole words are appended, so a byte boundary of the stream
                // sits where the remaining count is a multiple of 8.
                consume = {4'd0, cnt_q[2:0]};
                state_d = S_LEN;
            end
            S_LEN: begin
                if (cnt_q >= 7'd16) begin
                    len_d   = buf_q[15:0];
                    consume = 7'd16;
                    state_d = S_NLEN;
                end
            end
            S_NLEN: begin
                if (cnt_q >= 7'd16) begin
                    consume = 7'd16;
                    if (nlen != ~len_q) begin
                        err_d   = 1'b1;
                        code_d  = 2'd2;
                        state_d = S_ERR;
                    end else if (32'(len_q) > MAX_LEN) begin
                        err_d   = 1'b1;
                        code_d  = 2'd3;
                        state_d = S_ERR;
                    end else if (len_q == 16'd0) begin
                        state_d = S_BEND;
                    end else begin
                        rem_d   = len_q;
                        state_d = S_COPY;
                    end
                end
            end
            S_COPY: begin
                if ((cnt_q >= 7'd8) && !full_out) begin
                    wr_en_d = 1'b1;
                    dout_d  = buf_q[7:0];
                    consume = 7'd8;
                    rem_d   = rem_q - 16'd1;
                    if (rem_q == 16'd1) state_d = S_BEND;
                end
            end
            S_BEND: begin
                bdone_d = 1'b1;
                if (last_q) begin
                    sdone_d = 1'b1;
                    // Drop what is left of the partially used word; the next
                    // stream starts on a fresh word.
                    consume = {2'd0, cnt_q[4:0]};
                end
                state_d = S_HDR;
            end
            default: begin
                state_d = S_ERR;
            end
        endcase
    end

    // Consume first, then append an arriving word at the post-consume count.
    always_comb begin
        cnt_post = cnt_q - consume;
        buf_d    = buf_q >> consume;
        cnt_d    = cnt_post;
        if (pend_q && (state_q != S_ERR)) begin
            buf_d = buf_d | ({32'd0, din_32} << cnt_post);
            cnt_d = cnt_post + 7'd32;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_HDR;
            buf_q   <= '0;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            len_q   <= '0;
            rem_q   <= '0;
            wr_en_q <= 1'b0;
            dout_q  <= '0;
            bdone_q <= 1'b0;
            sdone_q <= 1'b0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            pend_q  <= rd_en_in;
            len_q   <= len_d;
            rem_q   <= rem_d;
            wr_en_q <= wr_en_d;
            dout_q  <= dout_d;
            bdone_q <= bdone_d;
            sdone_q <= sdone_d;
            last_q  <= last_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    assign wr_en_out   = wr_en_q;
    assign dout_byte   = dout_q;
    assign block_done  = bdone_q;
    assign stream_done = sdone_q;
    assign last_block  = last_q;
    assign error       = err_q;
    assign error_code  = code_q;

endmodule

// File: tb/tb_gzip_stored_block_decoder.sv
// Directed testbench for gzip_stored_block_decoder: a table of complete
// streams with expected bytes/flags, plus hand sequences for back-pressure
// and mid-stream reset.
module tb_gzip_stored_block_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        empty_in;
    logic        rd_en_in;
    logic [31:0] din_32 = '0;
    logic        full_out = 1'b0;
    logic        wr_en_out;
    logic [7:0]  dout_byte;
    logic        block_done;
    logic        stream_done;
    logic        last_block;
    logic        error;
    logic [1:0]  error_code;

    always #5 clk = ~clk;

    gzip_stored_block_decoder dut (
        .clk(clk), .rst(rst), .empty_in(empty_in), .rd_en_in(rd_en_in),
        .din_32(din_32), .full_out(full_out), .wr_en_out(wr_en_out),
        .dout_byte(dout_byte), .block_done(block_done),
        .stream_done(stream_done), .last_block(last_block),
        .error(error), .error_code(error_code)
    );

    // Source FIFO model
    logic [31:0] mem [256];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign empty_in = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (rst) rd_ptr <= wr_ptr;
        else if (rd_en_in && !empty_in) begin
            din_32 <= mem[rd_ptr & 255];
            rd_ptr <= rd_ptr + 1;
        end
    end

    // Output monitor
    logic       clr = 1'b1;
    logic [7:0] obuf [16];
    int out_cnt, bd_cnt, sd_cnt, rd_err, full_viol;
    logic full_prev;

    always @(negedge clk) begin
        if (clr) begin
            out_cnt = 0; bd_cnt = 0; sd_cnt = 0; rd_err = 0; full_viol = 0;
            full_prev = 1'b0;
        end else begin
            if (wr_en_out) begin
                if (out_cnt < 16) obuf[out_cnt] = dout_byte;
                out_cnt++;
                if (full_prev) full_viol++;
            end
            if (block_done)  bd_cnt++;
            if (stream_done) sd_cnt++;
            if (error && rd_en_in) rd_err++;
            full_prev = full_out;
        end
    end

    int nchk = 0;
    int nfail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk); #1;
        rst = 1'b1; clr = 1'b1; full_out = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk({tag, " reset outputs"},
            {19'd0, rd_en_in, wr_en_out, block_done, stream_done, last_block,
             error, error_code, dout_byte}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; clr = 1'b0;
    endtask

    task automatic load(input logic [127:0] b, input int nb);
        for (int i = 0; i < (nb + 3) / 4; i++) begin
            mem[wr_ptr & 255] = b[32*i +: 32];
            wr_ptr++;
        end
    endtask

    task automatic wait_bytes(input string tag, input int n);
        int k;
        k = 0;
        while (out_cnt < n && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (out_cnt < n) begin
            nchk++; nfail++;
            $display("FAIL %s timeout: got %0d bytes, expected %0d", tag, out_cnt, n);
        end
    endtask

    typedef struct packed {
        logic [7:0]   nb;
        logic [127:0] bytes;
        logic [7:0]   nout;
        logic [31:0]  outs;
        logic         err;
        logic [1:0]   code;
        logic [3:0]   nbd;
        logic [3:0]   nsd;
        logic         last;
    } vec_t;

    function automatic vec_t mk(input int nb, input logic [127:0] b, input int nout,
                                input logic [31:0] o, input logic e, input logic [1:0] c,
                                input int nbd, input int nsd, input logic l);
        vec_t v;
        v.nb = 8'(nb); v.bytes = b; v.nout = 8'(nout); v.outs = o;
        v.err = e; v.code = c; v.nbd = 4'(nbd); v.nsd = 4'(nsd); v.last = l;
        return v;
    endfunction

    vec_t vt [7];

    initial begin
        // "abc" stored block, BFINAL=1
        vt[0] = mk(8, 128'h636261FF_FC000301, 3, 32'h00636261, 0, 0, 1, 1, 1);
        // "xy" (BFINAL=0) then "z" (BFINAL=1)
        vt[1] = mk(13, 128'h0000007A_FFFE0001_017978FF_FD000200, 3, 32'h007A7978, 0, 0, 2, 1, 1);
        // NLEN corrupt
        vt[2] = mk(12, 128'h11223344_636261FE_FC000301, 0, 0, 1, 2, 0, 0, 1);
        // BTYPE=01
        vt[3] = mk(8, 128'h00000000_00000003, 0, 0, 1, 1, 0, 0, 1);
        // LEN=0 final block
        vt[4] = mk(5, 128'h000000FF_FF000001, 0, 0, 0, 0, 1, 1, 1);
        // BTYPE=10, BFINAL=0
        vt[5] = mk(8, 128'h00000000_00000004, 0, 0, 1, 1, 0, 0, 0);
        // BTYPE=11, BFINAL=1
        vt[6] = mk(8, 128'h00000000_00000007, 0, 0, 1, 1, 0, 0, 1);

        for (int i = 0; i < 7; i++) begin
            do_reset($sformatf("v%0d", i));
            load(vt[i].bytes, int'(vt[i].nb));
            repeat (60) @(negedge clk);
            chk($sformatf("v%0d nbytes", i), out_cnt, 32'(vt[i].nout));
            for (int j = 0; j < int'(vt[i].nout); j++)
                chk($sformatf("v%0d byte%0d", i, j), 32'(obuf[j]), 32'(vt[i].outs[8*j +: 8]));
            chk($sformatf("v%0d error", i), 32'(error), 32'(vt[i].err));
            chk($sformatf("v%0d error_code", i), 32'(error_code), 32'(vt[i].code));
            chk($sformatf("v%0d block_done", i), bd_cnt, 32'(vt[i].nbd));
            chk($sformatf("v%0d stream_done", i), sd_cnt, 32'(vt[i].nsd));
            chk($sformatf("v%0d last_block", i), 32'(last_block), 32'(vt[i].last));
            if (vt[i].err) chk($sformatf("v%0d rd after err", i), rd_err, 0);
        end

        // Back-pressure: LEN=8, full_out raised mid-copy for 5 cycles
        begin
            int at_set, at_rel;
            do_reset("bp");
            load(128'h00000017_16151413_121110FF_F7000801, 13);
            wait_bytes("bp pre", 2);
            @(posedge clk); #1;
            full_out = 1'b1;
            at_set = out_cnt;
            repeat (5) @(posedge clk);
            #1;
            at_rel = out_cnt;
            full_out = 1'b0;
            chk("bp stalled", 32'(at_rel <= at_set + 1), 1);
            repeat (40) @(negedge clk);
            chk("bp nbytes", out_cnt, 8);
            for (int j = 0; j < 8; j++)
                chk($sformatf("bp byte%0d", j), 32'(obuf[j]), 32'(8'h10 + j));
            chk("bp write while full", full_viol, 0);
            chk("bp stream_done", sd_cnt, 1);
        end

        // Reset after 2 of 4 payload bytes, then a fresh "abc" stream
        do_reset("mid0");
        load(128'h00000044_434241FF_FB000401, 9);
        wait_bytes("mid pre", 2);
        do_reset("mid1");
        chk("mid flags cleared", {29'd0, error, last_block, stream_done}, 0);
        load(128'h636261FF_FC000301, 8);
        repeat (60) @(negedge clk);
        chk("mid nbytes", out_cnt, 3);
        for (int j = 0; j < 3; j++)
            chk($sformatf("mid byte%0d", j), 32'(obuf[j]), 32'(8'h61 + j));
        chk("mid block_done", bd_cnt, 1);
        chk("mid stream_done", sd_cnt, 1);
        chk("mid error", 32'(error), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
        $finish;
    end

endmodule
